// File: rtl/msi_bus_memory_controller.sv
// msi_bus_memory_controller: shared-bus arbiter, snoop forwarder and main
// memory for a two-core MSI snoopy system. Write-backs retire first, then one
// bus request at a time is snooped to the peer core and filled either from the
// peer (abort) or from memory after MEM_LATENCY wait cycles.
module msi_bus_memory_controller #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [1:0]        req_type0,
  input  logic [1:0]        req_type1,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  output logic [1:0]        req_ack,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_from_cache,
  input  logic [1:0]        wb_valid,
  input  logic [ADDR_W-1:0] wb_addr0,
  input  logic [ADDR_W-1:0] wb_addr1,
  input  logic [DATA_W-1:0] wb_data0,
  input  logic [DATA_W-1:0] wb_data1,
  output logic [1:0]        wb_ack,
  output logic [1:0]        snoop_valid,
  output logic [1:0]        snoop_type,
  output logic [ADDR_W-1:0] snoop_addr,
  input  logic [1:0]        snoop_abort,
  input  logic [DATA_W-1:0] snoop_data0,
  input  logic [DATA_W-1:0] snoop_data1,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [1:0] T_INVALIDATE = 2'b00;
  localparam logic [1:0] T_ILLEGAL    = 2'b11;

  typedef enum logic [1:0] {IDLE, SNOOP, MEM_WAIT, RESPOND} state_t;

  state_t              state_reg;
  logic                rr_ptr_reg;
  logic                owner_reg;
  logic [1:0]          type_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [CNT_W-1:0]    wait_cnt_reg;
  logic [1:0]          req_ack_reg;
  logic [1:0]          wb_ack_reg;
  logic [1:0]          snoop_valid_reg;
  logic [DATA_W-1:0]   resp_data_reg;
  logic                resp_from_cache_reg;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   mem_rdata_reg;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // Per-core views of the flat port list so cores can be selected by index.
  logic [1:0]          req_type_a  [2];
  logic [ADDR_W-1:0]   req_addr_a  [2];
  logic [ADDR_W-1:0]   wb_addr_a   [2];
  logic [DATA_W-1:0]   wb_data_a   [2];
  logic [DATA_W-1:0]   snoop_data_a[2];
  logic [1:0]          req_legal;
  logic [1:0]          wb_pending;
  logic                req_sel;
  logic                req_peer;
  logic                wb_sel;
  logic                peer;

  assign req_type_a[0]   = req_type0;
  assign req_type_a[1]   = req_type1;
  assign req_addr_a[0]   = req_addr0;
  assign req_addr_a[1]   = req_addr1;
  assign wb_addr_a[0]    = wb_addr0;
  assign wb_addr_a[1]    = wb_addr1;
  assign wb_data_a[0]    = wb_data0;
  assign wb_data_a[1]    = wb_data1;
  assign snoop_data_a[0] = snoop_data0;
  assign snoop_data_a[1] = snoop_data1;

  // A write-back whose ack is currently showing is still held high by the core
  // for that cycle; masking it stops the same write-back being served twice.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_core
      assign req_legal[gi]  = req_valid[gi] && (req_type_a[gi] != T_ILLEGAL);
      assign wb_pending[gi] = wb_valid[gi] && !wb_ack_reg[gi];
    end
  endgenerate

  // Round-robin pick: the core at rr_ptr wins if it is asking, else the other.
  assign req_sel  = req_legal[rr_ptr_reg]  ? rr_ptr_reg : ~rr_ptr_reg;
  assign wb_sel   = wb_pending[rr_ptr_reg] ? rr_ptr_reg : ~rr_ptr_reg;
  assign req_peer = ~req_sel;
  assign peer     = ~owner_reg;

  // Single memory write port shared by write-backs (IDLE) and peer flushes (SNOOP).
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (state_reg == IDLE && wb_pending != 2'b00) begin
      mem_we    = 1'b1;
      mem_waddr = wb_addr_a[wb_sel];
      mem_wdata = wb_data_a[wb_sel];
    end else if (state_reg == SNOOP && type_reg != T_INVALIDATE && snoop_abort[peer]) begin
      mem_we    = 1'b1;
      mem_waddr = addr_reg;
      mem_wdata = snoop_data_a[peer];
    end
  end

  // Memory array: contents survive reset, but a write on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
    mem_rdata_reg <= mem[addr_reg];
  end

  // Bus FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg           <= IDLE;
      rr_ptr_reg          <= 1'b0;
      owner_reg           <= 1'b0;
      type_reg            <= '0;
      addr_reg            <= '0;
      wait_cnt_reg        <= '0;
      req_ack_reg         <= '0;
      wb_ack_reg          <= '0;
      snoop_valid_reg     <= '0;
      resp_data_reg       <= '0;
      resp_from_cache_reg <= 1'b0;
    end else begin
      req_ack_reg     <= '0;
      wb_ack_reg      <= '0;
      snoop_valid_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (wb_pending != 2'b00) begin
            wb_ack_reg[wb_sel] <= 1'b1;
          end else if (req_legal != 2'b00) begin
            owner_reg                 <= req_sel;
            type_reg                  <= req_type_a[req_sel];
            addr_reg                  <= req_addr_a[req_sel];
            snoop_valid_reg[req_peer] <= 1'b1;
            state_reg                 <= SNOOP;
          end
        end
        SNOOP: begin
          if (type_reg == T_INVALIDATE) begin
            resp_data_reg          <= '0;
            resp_from_cache_reg    <= 1'b0;
            req_ack_reg[owner_reg] <= 1'b1;
            state_reg              <= RESPOND;
          end else if (snoop_abort[peer]) begin
            resp_data_reg          <= snoop_data_a[peer];
            resp_from_cache_reg    <= 1'b1;
            req_ack_reg[owner_reg] <= 1'b1;
            state_reg              <= RESPOND;
          end else begin
            wait_cnt_reg <= CNT_W'(MEM_LATENCY);
            state_reg    <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (wait_cnt_reg <= CNT_W'(1)) begin
            resp_data_reg          <= mem_rdata_reg;
            resp_from_cache_reg    <= 1'b0;
            req_ack_reg[owner_reg] <= 1'b1;
            state_reg              <= RESPOND;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end
        end
        RESPOND: begin
          rr_ptr_reg <= peer;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ack         = req_ack_reg;
  assign wb_ack          = wb_ack_reg;
  assign snoop_valid     = snoop_valid_reg;
  assign snoop_type      = type_reg;
  assign snoop_addr      = addr_reg;
  assign resp_data       = resp_data_reg;
  assign resp_from_cache = resp_from_cache_reg;
  assign busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_msi_bus_memory_controller.sv
// Scoreboard bench for msi_bus_memory_controller: stimulus pushes expected
// snoops, fills and write-back acks; a negedge monitor pops and compares.
module tb_msi_bus_memory_controller;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam logic [1:0] T_INV = 2'b00;
  localparam logic [1:0] T_WM  = 2'b01;
  localparam logic [1:0] T_RM  = 2'b10;
  localparam logic [1:0] T_BAD = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_type0, req_type1;
  logic [ADDR_W-1:0] req_addr0, req_addr1;
  logic [1:0]        req_ack;
  logic [DATA_W-1:0] resp_data;
  logic              resp_from_cache;
  logic [1:0]        wb_valid;
  logic [ADDR_W-1:0] wb_addr0, wb_addr1;
  logic [DATA_W-1:0] wb_data0, wb_data1;
  logic [1:0]        wb_ack;
  logic [1:0]        snoop_valid;
  logic [1:0]        snoop_type;
  logic [ADDR_W-1:0] snoop_addr;
  logic [1:0]        snoop_abort;
  logic [DATA_W-1:0] snoop_data0, snoop_data1;
  logic              busy;

  logic [1:0]        abort_en;
  logic [DATA_W-1:0] abort_data [2];

  msi_bus_memory_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_type0(req_type0), .req_type1(req_type1),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_ack(req_ack), .resp_data(resp_data), .resp_from_cache(resp_from_cache),
    .wb_valid(wb_valid), .wb_addr0(wb_addr0), .wb_addr1(wb_addr1),
    .wb_data0(wb_data0), .wb_data1(wb_data1), .wb_ack(wb_ack),
    .snoop_valid(snoop_valid), .snoop_type(snoop_type), .snoop_addr(snoop_addr),
    .snoop_abort(snoop_abort), .snoop_data0(snoop_data0), .snoop_data1(snoop_data1),
    .busy(busy)
  );

  // Peer caches: answer a snoop combinationally when enabled.
  assign snoop_abort = snoop_valid & abort_en;
  assign snoop_data0 = abort_data[0];
  assign snoop_data1 = abort_data[1];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct { logic [1:0] mask; logic [1:0] typ; logic [ADDR_W-1:0] addr; int cyc; } snoop_t;
  typedef struct { logic [1:0] mask; logic [DATA_W-1:0] data; logic rfc; int cyc; } resp_t;
  typedef struct { logic [1:0] mask; int cyc; } wb_t;

  snoop_t snoop_q[$];
  resp_t  resp_q[$];
  wb_t    wb_q[$];
  snoop_t mon_s;
  resp_t  mon_r;
  wb_t    mon_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one line per observed transaction, compared against the queues.
  always @(negedge clk) begin
    if (snoop_valid != 2'b00) begin
      if (snoop_q.size() == 0) begin
        check("unexpected_snoop", 32'(snoop_valid), 32'd0);
      end else begin
        mon_s = snoop_q.pop_front();
        $display("snoop   cyc=%0d valid=%b type=%b addr=0x%03h", cyc, snoop_valid, snoop_type, snoop_addr);
        check("snoop_valid", 32'(snoop_valid), 32'(mon_s.mask));
        check("snoop_type", 32'(snoop_type), 32'(mon_s.typ));
        check("snoop_addr", 32'(snoop_addr), 32'(mon_s.addr));
        check("snoop_cycle", 32'(cyc), 32'(mon_s.cyc));
      end
    end
    if (req_ack != 2'b00) begin
      if (resp_q.size() == 0) begin
        check("unexpected_req_ack", 32'(req_ack), 32'd0);
      end else begin
        mon_r = resp_q.pop_front();
        $display("req_ack cyc=%0d ack=%b data=0x%08h from_cache=%b", cyc, req_ack, resp_data, resp_from_cache);
        check("req_ack", 32'(req_ack), 32'(mon_r.mask));
        check("resp_data", resp_data, mon_r.data);
        check("resp_from_cache", 32'(resp_from_cache), 32'(mon_r.rfc));
        check("ack_cycle", 32'(cyc), 32'(mon_r.cyc));
      end
    end
    if (wb_ack != 2'b00) begin
      if (wb_q.size() == 0) begin
        check("unexpected_wb_ack", 32'(wb_ack), 32'd0);
      end else begin
        mon_w = wb_q.pop_front();
        $display("wb_ack  cyc=%0d ack=%b", cyc, wb_ack);
        check("wb_ack", 32'(wb_ack), 32'(mon_w.mask));
        check("wb_cycle", 32'(cyc), 32'(mon_w.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_snoop(input logic [1:0] m, input logic [1:0] t, input logic [ADDR_W-1:0] a, input int c);
    snoop_q.push_back('{m, t, a, c});
  endtask

  task automatic exp_resp(input logic [1:0] m, input logic [DATA_W-1:0] d, input logic rfc, input int c);
    resp_q.push_back('{m, d, rfc, c});
  endtask

  task automatic start_req(input int core, input logic [1:0] t, input logic [ADDR_W-1:0] a);
    req_valid[core] = 1'b1;
    if (core == 0) begin
      req_type0 = t;
      req_addr0 = a;
    end else begin
      req_type1 = t;
      req_addr1 = a;
    end
  endtask

  task automatic start_wb(input int core, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_valid[core] = 1'b1;
    if (core == 0) begin
      wb_addr0 = a;
      wb_data0 = d;
    end else begin
      wb_addr1 = a;
      wb_data1 = d;
    end
  endtask

  // Bounded waits: return in the cycle the ack is visible (or after 40 cycles).
  task automatic wait_ack(input int core);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!req_ack[core] && n < 40);
    check("req_ack_seen", 32'(req_ack[core]), 32'd1);
  endtask

  task automatic wait_wb(input int core);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!wb_ack[core] && n < 40);
    check("wb_ack_seen", 32'(wb_ack[core]), 32'd1);
  endtask

  // Requester drops req_valid the cycle after its ack, then the bus idles a cycle.
  task automatic finish_req(input int core);
    tick();
    req_valid[core] = 1'b0;
    tick();
  endtask

  task automatic do_wb(input int core, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    start_wb(core, a, d);
    wb_q.push_back('{(core == 0) ? 2'b01 : 2'b10, cyc + 1});
    wait_wb(core);
    tick();
    wb_valid[core] = 1'b0;
    tick();
  endtask

  initial begin
    int p;
    rst = 1'b1;
    req_valid = '0; req_type0 = '0; req_type1 = '0; req_addr0 = '0; req_addr1 = '0;
    wb_valid = '0; wb_addr0 = '0; wb_addr1 = '0; wb_data0 = '0; wb_data1 = '0;
    abort_en = '0; abort_data[0] = '0; abort_data[1] = '0;
    repeat (3) tick();

    // Reset state
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_wb_ack", 32'(wb_ack), 32'd0);
    check("rst_snoop_valid", 32'(snoop_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_from_cache", 32'(resp_from_cache), 32'd0);
    rst = 1'b0;
    tick();

    // Both cores READ_MISS together: core0 (rr_ptr=0) first, core1 next.
    start_req(0, T_RM, 9'h005);
    start_req(1, T_RM, 9'h006);
    p = cyc;
    exp_snoop(2'b10, T_RM, 9'h005, p + 1);
    exp_resp(2'b01, 32'h0, 1'b0, p + 4);
    exp_snoop(2'b01, T_RM, 9'h006, p + 6);
    exp_resp(2'b10, 32'h0, 1'b0, p + 9);
    wait_ack(0);
    tick();
    req_valid[0] = 1'b0;
    wait_ack(1);
    finish_req(1);

    // Core0 READ_MISS 0x005, memory fill of zero after MEM_LATENCY.
    start_req(0, T_RM, 9'h005);
    p = cyc;
    exp_snoop(2'b10, T_RM, 9'h005, p + 1);
    exp_resp(2'b01, 32'h0, 1'b0, p + 4);
    tick();
    check("busy_in_snoop", 32'(busy), 32'd1);
    wait_ack(0);
    finish_req(0);

    // Both again with rr_ptr=1: core1 wins this time.
    start_req(0, T_RM, 9'h007);
    start_req(1, T_RM, 9'h008);
    p = cyc;
    exp_snoop(2'b01, T_RM, 9'h008, p + 1);
    exp_resp(2'b10, 32'h0, 1'b0, p + 4);
    exp_snoop(2'b10, T_RM, 9'h007, p + 6);
    exp_resp(2'b01, 32'h0, 1'b0, p + 9);
    wait_ack(1);
    tick();
    req_valid[1] = 1'b0;
    wait_ack(0);
    finish_req(0);

    // Core1 write-back, then core0 reads it back from memory.
    do_wb(1, 9'h025, 32'hDEADBEEF);
    start_req(0, T_RM, 9'h025);
    p = cyc;
    exp_snoop(2'b10, T_RM, 9'h025, p + 1);
    exp_resp(2'b01, 32'hDEADBEEF, 1'b0, p + 4);
    wait_ack(0);
    finish_req(0);

    // Write-back and request to the same address together: write-back retires first.
    start_wb(1, 9'h030, 32'hCAFEF00D);
    start_req(0, T_RM, 9'h030);
    p = cyc;
    wb_q.push_back('{2'b10, p + 1});
    exp_snoop(2'b10, T_RM, 9'h030, p + 2);
    exp_resp(2'b01, 32'hCAFEF00D, 1'b0, p + 5);
    wait_wb(1);
    tick();
    wb_valid[1] = 1'b0;
    wait_ack(0);
    finish_req(0);

    // Core0 WRITE_MISS 0x003, core1 aborts with its copy; memory takes the flush.
    abort_en[1] = 1'b1;
    abort_data[1] = 32'h12345678;
    start_req(0, T_WM, 9'h003);
    p = cyc;
    exp_snoop(2'b10, T_WM, 9'h003, p + 1);
    exp_resp(2'b01, 32'h12345678, 1'b1, p + 2);
    wait_ack(0);
    abort_en[1] = 1'b0;
    finish_req(0);
    start_req(1, T_RM, 9'h003);
    p = cyc;
    exp_snoop(2'b01, T_RM, 9'h003, p + 1);
    exp_resp(2'b10, 32'h12345678, 1'b0, p + 4);
    wait_ack(1);
    finish_req(1);

    // Core1 INVALIDATE 0x010 while core0 would abort: data 0, no flush to memory.
    do_wb(0, 9'h010, 32'h0BADCAFE);
    abort_en[0] = 1'b1;
    abort_data[0] = 32'h11111111;
    start_req(1, T_INV, 9'h010);
    p = cyc;
    exp_snoop(2'b01, T_INV, 9'h010, p + 1);
    exp_resp(2'b10, 32'h0, 1'b0, p + 2);
    wait_ack(1);
    abort_en[0] = 1'b0;
    finish_req(1);
    start_req(1, T_RM, 9'h010);
    p = cyc;
    exp_snoop(2'b01, T_RM, 9'h010, p + 1);
    exp_resp(2'b10, 32'h0BADCAFE, 1'b0, p + 4);
    wait_ack(1);
    finish_req(1);

    // Type 11 is never accepted.
    start_req(0, T_BAD, 9'h000);
    repeat (6) tick();
    check("illegal_type_busy", 32'(busy), 32'd0);
    req_valid[0] = 1'b0;
    tick();

    // Reset during SNOOP with an abort: no ack and no flush to memory.
    abort_en[1] = 1'b1;
    abort_data[1] = 32'h55AA55AA;
    start_req(0, T_WM, 9'h040);
    p = cyc;
    exp_snoop(2'b10, T_WM, 9'h040, p + 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid[0] = 1'b0;
    abort_en[1] = 1'b0;
    check("rst_snoop_busy", 32'(busy), 32'd0);
    check("rst_snoop_req_ack", 32'(req_ack), 32'd0);
    tick();
    start_req(0, T_RM, 9'h040);
    p = cyc;
    exp_snoop(2'b10, T_RM, 9'h040, p + 1);
    exp_resp(2'b01, 32'h0, 1'b0, p + 4);
    wait_ack(0);
    finish_req(0);

    // Reset during MEM_WAIT: transaction dropped, next request served normally.
    start_req(0, T_RM, 9'h025);
    p = cyc;
    exp_snoop(2'b10, T_RM, 9'h025, p + 1);
    tick();
    tick();
    check("busy_in_mem_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid[0] = 1'b0;
    check("rst_wait_busy", 32'(busy), 32'd0);
    check("rst_wait_req_ack", 32'(req_ack), 32'd0);
    repeat (4) tick();
    start_req(1, T_RM, 9'h025);
    p = cyc;
    exp_snoop(2'b01, T_RM, 9'h025, p + 1);
    exp_resp(2'b10, 32'hDEADBEEF, 1'b0, p + 4);
    wait_ack(1);
    finish_req(1);

    repeat (5) tick();
    check("snoop_queue_empty", 32'(snoop_q.size()), 32'd0);
    check("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    check("wb_queue_empty", 32'(wb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
